exception_writeback_pipe: RTL
=============================

# exception_writeback_pipe

Pipeline carrier that takes an instruction's execute-stage result, overflow flag and its rstatus code, and moves them through the X/M and M/W pipeline registers. At writeback it produces the register-file write port. When an add, sub or addi overflowed, it redirects the write to $30 (rstatus) with the code instead of writing the ALU result to rd. It sits directly downstream of the execute stage and its rstatus generator, and feeds the register file write port.

## Interface
Parameters:
- CNT_W, 16, width of saturating exception counter

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- x_valid  in  1  execute stage holds a real instruction
- x_insn  in  32  execute-stage instruction word
- x_alu_result  in  32  ALU result (PC+1 for jal)
- x_overflow  in  1  ALU overflow for this instruction
- x_rstatus  in  32  rstatus code: 1 add, 3 sub, 2 addi
- stall  in  1  freeze both pipeline registers
- flush  in  1  load bubble into X/M
- m_load_data  in  32  data-memory read data for the instruction in X/M
- m_insn  out  32  X/M instruction (to memory stage)
- m_alu_result  out  32  X/M ALU result (memory address)
- wb_we  out  1  register-file write enable
- wb_addr  out  5  register-file write address
- wb_data  out  32  register-file write data
- exc_seen  out  1  writeback instruction is a taken overflow exception
- exc_count  out  CNT_W  saturating count of exceptions retired

## Operation
- Opcode is insn[31:27]. ALUop is insn[6:2]. rd is insn[26:22].
- X/M register fields: valid, insn, alu_result, exc.
  - exc = x_overflow & (opcode==00000 & ALUop∈{00000,00001} | opcode==00101).
  - Overflow on any other instruction is ignored.
- M/W register fields: the X/M fields, plus load_data captured from m_load_data.
- Writeback decode from M/W, when valid:
  - exc=1: wb_addr=30, wb_data=rstatus, wb_we=1.
  - R-type (00000) or addi (00101): wb_addr=rd, wb_data=alu_result.
  - lw (01000): wb_addr=rd, wb_data=load_data.
  - jal (00011): wb_addr=31, wb_data=alu_result.
  - setx (10101): wb_addr=30, wb_data={5'b0, insn[26:0]}.
  - All other opcodes: wb_we=0.
  - wb_we is forced to 0 when wb_addr==0 and the write is not an exception.
- rstatus is captured into X/M alongside exc and carried to M/W. It is used only when exc=1.
- exc_seen = M/W valid & exc.
- exc_count increments by 1 on each clock edge where exc_seen=1 and stall=0. It saturates at all-ones.
- Invalid (bubble) entries: wb_we=0, exc_seen=0, no count change.

## Timing
- Reset (asynchronous): both registers are cleared to valid=0, insn=0, all data=0.
  - Resulting outputs: wb_we=0, wb_addr=0, wb_data=0, exc_seen=0, exc_count=0, m_insn=0, m_alu_result=0.
- Each rising edge with stall=0:
  - X/M ← execute inputs (bubble if flush=1 or x_valid=0).
  - M/W ← X/M, plus m_load_data.
- Rising edge with stall=1:
  - M/W holds.
  - X/M holds, unless flush=1, in which case X/M becomes a bubble (flush beats stall).
- Latency: inputs sampled at edge N appear on wb_* after edge N+1, with 2-cycle occupancy. All wb_* outputs are combinational from M/W.
- Back-to-back exceptions retire on consecutive cycles, and each increments exc_count.
- An exception held in M/W during a stall counts once.
- Reset asserted mid-operation discards in-flight instructions immediately, with no write-enable glitch after reset asserts.

## Test plan
- Reset while the pipe is full → wb_we=0 and exc_count=0 at once; the first instruction after deassert reaches wb after 2 edges.
- add $5 (rd=5, ALUop 00000), overflow=1, rstatus=1 → wb_addr=30, wb_data=1, exc_seen=1, exc_count=1. The same add with overflow=0 and result 0x1234 → wb_addr=5, wb_data=0x1234.
- Test each exception kind:
  - sub overflow → rstatus 3 to $30.
  - addi overflow → 2 to $30.
  - sw opcode with x_overflow=1 → wb_we=0, no count.
- lw $7 with m_load_data=0xCAFE → wb_addr=7, wb_data=0xCAFE. jal → $31 gets PC+1. setx T=0x100 → $30 gets 0x100. add to $0 without overflow → wb_we=0.
- Stall for 3 cycles with an exception in M/W → outputs held, exc_count increments once. flush together with stall → X/M becomes a bubble and never writes back.
- Preload exc_count to all-ones through repeated exceptions (CNT_W=4 build) → the 16th and later exceptions leave the count at 0xF.

Source files
------------

// File: rtl/exception_writeback_pipe.sv
// X/M and M/W pipeline registers feeding the register-file write port.
// Overflowing add/sub/addi are redirected to $30 with their rstatus code.
module exception_writeback_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_valid,
  input  logic [31:0]      x_insn,
  input  logic [31:0]      x_alu_result,
  input  logic             x_overflow,
  input  logic [31:0]      x_rstatus,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      m_load_data,
  output logic [31:0]      m_insn,
  output logic [31:0]      m_alu_result,
  output logic             wb_we,
  output logic [4:0]       wb_addr,
  output logic [31:0]      wb_data,
  output logic             exc_seen,
  output logic [CNT_W-1:0] exc_count
);
  localparam int STAGES = 2;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] alu_result;
    logic        exc;
    logic [31:0] rstatus;
  } xm_t;

  typedef struct packed {
    xm_t         xm;
    logic [31:0] load_data;
  } mw_t;

  logic [STAGES:1] vld_pipe;  // [1] = X/M, [2] = M/W
  xm_t xm_d, xm_q;
  mw_t mw_q;
  logic x_exc;

  // Only add, sub and addi can raise an overflow exception
  always_comb begin
    x_exc = x_overflow &
            (((x_insn[31:27] == OP_RTYPE) &&
              ((x_insn[6:2] == ALU_ADD) || (x_insn[6:2] == ALU_SUB))) ||
             (x_insn[31:27] == OP_ADDI));
    xm_d = '0;
    if (x_valid) begin
      xm_d.insn       = x_insn;
      xm_d.alu_result = x_alu_result;
      xm_d.exc        = x_exc;
      xm_d.rstatus    = x_rstatus;
    end
  end

  // Flush wins over stall on X/M; M/W only advances when not stalled
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      xm_q      <= '0;
      mw_q      <= '0;
      exc_count <= '0;
    end else begin
      if (flush) begin
        vld_pipe[1] <= 1'b0;
        xm_q        <= '0;
      end else if (!stall) begin
        vld_pipe[1] <= x_valid;
        xm_q        <= xm_d;
      end
      if (!stall) begin
        vld_pipe[2] <= vld_pipe[1];
        mw_q        <= '{xm: xm_q, load_data: m_load_data};
      end
      if (exc_seen && !stall && (exc_count != '1))
        exc_count <= exc_count + 1'b1;
    end
  end

  assign m_insn       = xm_q.insn;
  assign m_alu_result = xm_q.alu_result;
  assign exc_seen     = vld_pipe[2] & mw_q.xm.exc;

  always_comb begin
    wb_we   = 1'b0;
    wb_addr = 5'd0;
    wb_data = 32'd0;
    if (vld_pipe[2]) begin
      if (mw_q.xm.exc) begin
        wb_we   = 1'b1;
        wb_addr = 5'd30;
        wb_data = mw_q.xm.rstatus;
      end else begin
        unique case (mw_q.xm.insn[31:27])
          OP_RTYPE, OP_ADDI: begin
            wb_we   = 1'b1;
            wb_addr = mw_q.xm.insn[26:22];
            wb_data = mw_q.xm.alu_result;
          end
          OP_LW: begin
            wb_we   = 1'b1;
            wb_addr = mw_q.xm.insn[26:22];
            wb_data = mw_q.load_data;
          end
          OP_JAL: begin
            wb_we   = 1'b1;
            wb_addr = 5'd31;
            wb_data = mw_q.xm.alu_result;
          end
          OP_SETX: begin
            wb_we   = 1'b1;
            wb_addr = 5'd30;
            wb_data = {5'b0, mw_q.xm.insn[26:0]};
          end
          default: ;
        endcase
        // $0 is hardwired; normal writes to it are dropped
        if (wb_addr == 5'd0) wb_we = 1'b0;
      end
    end
  end
endmodule
